// File: rtl/pipe_collision_checker_if.sv
// Bar-select bus between the collision checker and the obstacle generator.
// The checker drives bar_sel; the generator answers combinationally with that bar's gap.
interface pipe_collision_checker_if;
   logic [2:0] bar_sel;
   logic [9:0] bar_pos;
   logic [9:0] bar_op;

   modport master (output bar_sel, input bar_pos, input bar_op);
   modport slave  (input bar_sel, output bar_pos, output bar_op);
endinterface

// File: rtl/pipe_collision_checker.sv
// Per-frame bird/bar collision scan with crash, score and level bookkeeping.
// One bar is evaluated per cycle; results are committed together in RESOLVE.
module pipe_collision_checker #(
   parameter int unsigned FIRST_BAR = 1,
   parameter int unsigned LAST_BAR  = 6,
   parameter int unsigned BAR_PITCH = 80,
   parameter int unsigned BAR_W     = 20,
   parameter int unsigned BIRD_SZ   = 10,
   parameter int unsigned SCREEN_H  = 480
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tick,
   input  logic                          pause,
   input  logic                          restart,
   input  logic [9:0]                    bird_x,
   input  logic [9:0]                    bird_y,
   pipe_collision_checker_if.master      bar,
   output logic                          crash,
   output logic [7:0]                    score,
   output logic [9:0]                    level,
   output logic                          level_up,
   output logic                          check_done
);

   typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

   state_t      state;
   logic [9:0]  bx_q;
   logic [9:0]  by_q;
   logic [7:0]  mask;
   logic [7:0]  pend_mask;
   logic        hit_acc;

   logic [10:0] bar_left;
   logic [10:0] bar_right;
   logic [10:0] bird_right;
   logic [10:0] bird_bottom;
   logic [10:0] gap_bottom;
   logic        overlap;
   logic        bar_hit;
   logic        bar_passed;
   logic        floor_hit;

   logic [7:0]  new_mask;
   logic [3:0]  pass_cnt;
   logic [8:0]  score_sum;
   logic [7:0]  score_next;
   logic        all_set;

   // Geometry of the bar currently on the bus, all in 11 bits so sums never wrap
   always_comb begin
      bar_left    = 11'(32'(bar.bar_sel) * BAR_PITCH);
      bar_right   = bar_left + 11'(BAR_W);
      bird_right  = {1'b0, bx_q} + 11'(BIRD_SZ);
      bird_bottom = {1'b0, by_q} + 11'(BIRD_SZ);
      gap_bottom  = {1'b0, bar.bar_pos} + {1'b0, bar.bar_op};
      overlap     = (bird_right > bar_left) && ({1'b0, bx_q} < bar_right);
      bar_hit     = overlap && (({1'b0, by_q} < {1'b0, bar.bar_pos}) || (bird_bottom > gap_bottom));
      bar_passed  = ({1'b0, bx_q} >= bar_right) && !mask[bar.bar_sel];
      floor_hit   = bird_bottom > 11'(SCREEN_H);
   end

   always_comb begin
      new_mask = mask | pend_mask;
      pass_cnt = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         pass_cnt = pass_cnt + 4'(pend_mask[i]);
      end
      score_sum  = {1'b0, score} + {5'd0, pass_cnt};
      score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
      all_set = 1'b1;
      for (int unsigned i = FIRST_BAR; i <= LAST_BAR; i++) begin
         all_set = all_set & new_mask[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bar.bar_sel <= '0;
         bx_q        <= '0;
         by_q        <= '0;
         mask        <= '0;
         pend_mask   <= '0;
         hit_acc     <= 1'b0;
         crash       <= 1'b0;
         score       <= '0;
         level       <= 10'd1;
         level_up    <= 1'b0;
         check_done  <= 1'b0;
      end else if (restart) begin
         // Cancels any scan in flight; level is deliberately kept
         state       <= IDLE;
         bar.bar_sel <= '0;
         mask        <= '0;
         pend_mask   <= '0;
         hit_acc     <= 1'b0;
         crash       <= 1'b0;
         score       <= '0;
         level_up    <= 1'b0;
         check_done  <= 1'b0;
      end else begin
         level_up   <= 1'b0;
         check_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tick && !pause && !crash) begin
                  bx_q        <= bird_x;
                  by_q        <= bird_y;
                  bar.bar_sel <= 3'(FIRST_BAR);
                  pend_mask   <= '0;
                  hit_acc     <= 1'b0;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               hit_acc <= hit_acc | bar_hit;
               if (bar_passed) begin
                  pend_mask[bar.bar_sel] <= 1'b1;
               end
               if (bar.bar_sel == 3'(LAST_BAR)) begin
                  state <= RESOLVE;
               end else begin
                  bar.bar_sel <= bar.bar_sel + 3'd1;
               end
            end
            RESOLVE: begin
               crash <= crash | hit_acc | floor_hit;
               score <= score_next;
               if (all_set) begin
                  mask     <= '0;
                  level    <= (level == 10'h3FF) ? level : level + 10'd1;
                  level_up <= 1'b1;
               end else begin
                  mask <= new_mask;
               end
               check_done  <= 1'b1;
               bar.bar_sel <= '0;
               state       <= IDLE;
            end
            default: begin
               state       <= IDLE;
               bar.bar_sel <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_collision_checker.sv
// Scoreboard bench: frame expectations are queued at tick time from a geometric
// reference model and popped by a monitor whenever check_done pulses.
module tb_pipe_collision_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       pause = 1'b0;
   logic       restart = 1'b0;
   logic [9:0] bird_x = '0;
   logic [9:0] bird_y = '0;
   logic       crash;
   logic [7:0] score;
   logic [9:0] level;
   logic       level_up;
   logic       check_done;

   logic [9:0] gap_top [8];
   logic [9:0] gap_h   [8];

   pipe_collision_checker_if bus ();

   always_comb begin
      bus.bar_pos = gap_top[bus.bar_sel];
      bus.bar_op  = gap_h[bus.bar_sel];
   end

   pipe_collision_checker dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .pause(pause), .restart(restart),
      .bird_x(bird_x), .bird_y(bird_y), .bar(bus),
      .crash(crash), .score(score), .level(level),
      .level_up(level_up), .check_done(check_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int crash;
      int score;
      int level;
      int lu;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   int   m_crash = 0;
   int   m_score = 0;
   int   m_level = 1;
   bit   m_mask [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_clear();
      m_crash = 0;
      m_score = 0;
      for (int i = 0; i < 8; i++) m_mask[i] = 1'b0;
   endtask

   // Reference: screen geometry of each bar applied with integer arithmetic
   task automatic model_frame(input int bx, input int by);
      exp_t e;
      bit   hit;
      bit   full;
      hit = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         int left;
         left = i * 80;
         if (bx + 10 > left && bx < left + 20 &&
             (by < int'(gap_top[i]) || by + 10 > int'(gap_top[i]) + int'(gap_h[i])))
            hit = 1'b1;
         if (bx >= left + 20 && !m_mask[i]) begin
            m_mask[i] = 1'b1;
            if (m_score < 255) m_score++;
         end
      end
      if (by + 10 > 480) hit = 1'b1;
      if (hit) m_crash = 1;
      full = 1'b1;
      for (int i = 1; i <= 6; i++) full &= m_mask[i];
      e.lu = 0;
      if (full) begin
         if (m_level < 1023) m_level++;
         e.lu = 1;
         for (int i = 0; i < 8; i++) m_mask[i] = 1'b0;
      end
      e.crash = m_crash;
      e.score = m_score;
      e.level = m_level;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (level_up && !check_done) chk("level_up_alone", level_up, 0);
         if (check_done) begin
            if (q.size() == 0) begin
               chk("unexpected_check_done", check_done, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("crash", crash, e.crash);
               chk("score", score, e.score);
               chk("level", level, e.level);
               chk("level_up", level_up, e.lu);
            end
         end
      end
   end

   task automatic set_all(input int pos, input int op);
      for (int i = 0; i < 8; i++) begin
         gap_top[i] = 10'(pos);
         gap_h[i]   = 10'(op);
      end
   endtask

   task automatic run_frame(input int bx, input int by, input bit pause_mid);
      bit scan;
      bird_x = 10'(bx);
      bird_y = 10'(by);
      tick   = 1'b1;
      scan   = !pause && (m_crash == 0);
      if (scan) model_frame(bx, by);
      step();
      tick = 1'b0;
      if (scan) begin
         chk("bar_sel_first", bus.bar_sel, 1);
         for (int j = 2; j <= 6; j++) begin
            step();
            chk("bar_sel_step", bus.bar_sel, j);
            if (pause_mid && j == 2) pause = 1'b1;
         end
         step();
         chk("done_early", check_done, 0);
         step();
         chk("done_k7", check_done, 1);
         chk("bar_sel_idle", bus.bar_sel, 0);
         step();
         chk("queue_drained", q.size(), 0);
         pause = 1'b0;
      end else begin
         repeat (3) begin
            step();
            chk("no_scan", bus.bar_sel, 0);
         end
      end
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
      model_clear();
      chk("restart_crash", crash, 0);
      chk("restart_score", score, 0);
      chk("restart_level", level, m_level);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      model_clear();
      set_all(240, 150);
      repeat (2) step();
      chk("rst_bar_sel", bus.bar_sel, 0);
      chk("rst_crash", crash, 0);
      chk("rst_score", score, 0);
      chk("rst_level", level, 1);
      chk("rst_level_up", level_up, 0);
      chk("rst_check_done", check_done, 0);
      rst_n = 1'b1;
      step();

      // Bird inside the gap, then above it, then below it
      run_frame(85, 250, 0);
      run_frame(85, 230, 0);
      chk("crash_above", crash, 1);
      run_frame(85, 250, 0);
      do_restart();
      run_frame(85, 385, 0);
      chk("crash_below", crash, 1);
      do_restart();

      // Gap extending past the floor: only the floor can be hit
      gap_top[1] = 10'd470;
      gap_h[1]   = 10'd150;
      run_frame(85, 475, 0);
      chk("floor_crash", crash, 1);
      do_restart();
      run_frame(85, 470, 0);
      chk("floor_edge_ok", crash, 0);

      // Passing bars and levelling up
      set_all(0, 1000);
      run_frame(100, 200, 0);
      run_frame(100, 200, 0);
      chk("pass_once", score, 1);
      run_frame(580, 200, 0);
      chk("level_two", level, 2);
      chk("score_kept", score, 6);

      // Restart in the middle of a scan
      do_restart();
      run_frame(420, 200, 0);
      chk("score_five", score, 5);
      bird_x = 10'd420;
      bird_y = 10'd475;
      tick   = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
      restart = 1'b1;
      step();
      restart = 1'b0;
      model_clear();
      chk("mid_restart_sel", bus.bar_sel, 0);
      chk("mid_restart_crash", crash, 0);
      chk("mid_restart_score", score, 0);
      chk("mid_restart_level", level, 2);
      repeat (8) begin
         step();
         chk("no_done_after_restart", check_done, 0);
      end

      // restart wins over tick
      bird_y  = 10'd200;
      tick    = 1'b1;
      restart = 1'b1;
      step();
      tick    = 1'b0;
      restart = 1'b0;
      repeat (3) begin
         step();
         chk("restart_over_tick", bus.bar_sel, 0);
      end

      // Pause at tick drops it; pause mid-scan does not abort
      pause = 1'b1;
      run_frame(100, 200, 0);
      pause = 1'b0;
      run_frame(100, 200, 1);
      chk("pause_mid_score", score, 1);

      // Async reset mid-scan
      tick = 1'b1;
      bird_x = 10'd300;
      step();
      tick = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("arst_bar_sel", bus.bar_sel, 0);
      chk("arst_crash", crash, 0);
      chk("arst_score", score, 0);
      chk("arst_level", level, 1);
      chk("arst_check_done", check_done, 0);
      q.delete();
      model_clear();
      m_level = 1;
      step();
      rst_n = 1'b1;
      step();

      // Randomized frames
      for (int f = 0; f < 150; f++) begin
         if (m_crash != 0 && $urandom_range(0, 2) != 0) do_restart();
         for (int i = 1; i <= 6; i++) begin
            gap_top[i] = 10'($urandom_range(0, 250));
            gap_h[i]   = 10'($urandom_range(80, 350));
         end
         pause = ($urandom_range(0, 9) == 0);
         run_frame(($urandom_range(0, 3) == 0) ? $urandom_range(560, 639) : $urandom_range(0, 639),
                   $urandom_range(60, 479), ($urandom_range(0, 4) == 0));
         pause = 1'b0;
      end

      // Score saturation
      do_restart();
      set_all(0, 1000);
      repeat (45) run_frame(580, 100, 0);
      chk("score_saturate", score, 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_collision_checker.md
Name: pipe_collision_checker

Overview:
- Reads the per-bar obstacle state (gap top and gap size) one bar at a time through a bar-select interface.
- Checks the bird's bounding box against each bar and against the screen floor.
- Maintains crash, score and level state and hands the level back to the obstacle generator.
- Sits between the bird physics block and the obstacle generator; runs once per frame tick.

Parameters:
- FIRST_BAR, 1, lowest bar index scanned
- LAST_BAR, 6, highest bar index scanned
- BAR_PITCH, 80, horizontal spacing; bar i left edge = i*BAR_PITCH
- BAR_W, 20, bar column width in pixels
- BIRD_SZ, 10, bird square side in pixels
- SCREEN_H, 480, floor y coordinate

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame strobe, synchronous to clk
- pause  in  1  high = no new scans start
- restart  in  1  clears crash, score and pass mask; keeps level
- bird_x  in  10  bird left edge
- bird_y  in  10  bird top edge
- bar_sel  out  3  index of the bar being read
- bar_pos  in  10  gap top for bar_sel; combinational from the generator
- bar_op  in  10  gap height for bar_sel; combinational from the generator
- crash  out  1  sticky collision flag
- score  out  8  bars passed in the current life
- level  out  10  current level, fed to the obstacle generator
- level_up  out  1  one-cycle pulse when the level increments
- check_done  out  1  one-cycle pulse when a frame check completes

Behaviour:
- Reset values: bar_sel=0, crash=0, score=0, level=1, level_up=0, check_done=0, pass mask=0, state=IDLE.
- IDLE:
  - If tick && !pause && !crash at edge k: latch bird_x/bird_y and set bar_sel=FIRST_BAR. Next state SCAN.
  - tick while paused or crashed is dropped.
- SCAN:
  - At each edge, sample bar_pos/bar_op for the current bar_sel and evaluate bar_sel.
  - Then bar_sel increments; after LAST_BAR is sampled, go to RESOLVE.
  - Edges k+1..k+6 sample bars 1..6.
- RESOLVE, one cycle:
  - At edge k+7, commit crash/score/level/mask.
  - check_done=1 for the following cycle; return to IDLE; bar_sel=0.
- All compares are 11-bit unsigned, so bar_pos+bar_op and bird_y+BIRD_SZ cannot overflow.
- Overlap of bar i: bird_x+BIRD_SZ > i*BAR_PITCH and bird_x < i*BAR_PITCH+BAR_W.
- Hit on bar i: overlap && (bird_y < bar_pos || bird_y+BIRD_SZ > bar_pos+bar_op).
- A gap with bar_pos+bar_op > SCREEN_H is legal; it simply extends to the floor.
- Floor hit: bird_y+BIRD_SZ > SCREEN_H, evaluated in RESOLVE.
- Passed bar i: bird_x >= i*BAR_PITCH+BAR_W and mask[i]==0.
  - Sets mask[i] and adds 1 to score for each newly passed bar, so several bars can count in one frame.
  - Score saturates at 255.
- Any hit in a frame sets crash in RESOLVE. Score still counts passes from that same frame.
- Level-up: when the mask has all of FIRST_BAR..LAST_BAR set after the commit:
  - level+1 (saturate 1023), level_up pulse aligned with check_done.
  - Mask clears; score is retained.
- crash is sticky until restart or reset.
- restart, any state, synchronous:
  - Clears crash, score and mask; forces IDLE and bar_sel=0; cancels any scan in flight.
  - No check_done is produced for the cancelled scan.
  - restart has priority over tick in the same cycle.
- pause asserted mid-scan does not abort; the scan completes.
- Async reset mid-scan returns every output to its reset value immediately.

Test Plan:
- Bar1 pos=240 op=150, bird_x=85 bird_y=250, tick -> bar_sel steps 1..6 on edges k+1..k+6; check_done at k+7; crash=0, score=0.
- Same bars, bird_y=230 (above gap) -> crash=1 at check_done. Separately, bird_y=385 (bottom 395 > 390) -> crash=1. A following tick produces no scan.
- Bar1 pos=470 op=150 (sum 620), bird_x=85 bird_y=475 -> no bar hit, but floor hit since 485 > 480 -> crash=1. Same with bird_y=465 -> crash=0.
- bird_x=100, all gaps cover bird -> score=1 (bar1 passed). Repeat tick at bird_x=100 -> score stays 1. bird_x=580 next frame -> score=6, level 1->2, level_up pulse coincident with check_done, mask cleared.
- restart asserted at edge k+3 of a scan with crash=1 and score=5 -> IDLE, bar_sel=0, crash=0, score=0, level unchanged, no check_done. tick and restart in the same cycle -> no scan starts.
- pause=1 with tick -> no bar_sel activity. pause raised at k+2 -> scan completes and check_done still occurs at k+7. rst_n low at k+4 -> immediate reset values, level=1.
